pc_gen: RTL
===========

PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 SHALL provide parameter ADDR_W, default 64, PC/address width in bits.
REQ-002 SHALL provide parameter RESET_VEC, default 64'h0000_0000_8000_0000, first fetch address after reset, truncated to ADDR_W.
REQ-003 SHALL provide parameter CNT_W, default 64, fetch-counter width.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port pc_o  output  ADDR_W  current fetch PC.
REQ-007 SHALL have port pc_valid_o  output  1  pc_o valid for fetch.
REQ-008 SHALL have port pc_ready_i  input  1  fetch accepts pc_o this cycle.
REQ-009 SHALL have port redirect_i  input  1  branch/jump taken.
REQ-010 SHALL have port redirect_pc_i  input  ADDR_W  branch/jump target.
REQ-011 SHALL have port halt_i  input  1  halt request (ebreak).
REQ-012 SHALL have port halted_o  output  1  block in HALT state.
REQ-013 SHALL have port misalign_o  output  1  one-cycle pulse, rejected redirect target.
REQ-014 SHALL have port fetch_cnt_o  output  CNT_W  count of accepted fetches.

Function
REQ-015 SHALL implement states IDLE, RUN, HALT; fire = pc_valid_o & pc_ready_i.
REQ-016 IDLE: pc_valid_o=0; next cycle unconditionally RUN; pc_o holds RESET_VEC.
REQ-017 RUN: pc_valid_o=1; HALT: pc_valid_o=0, halted_o=1, pc_o frozen.
REQ-018 In RUN, next-PC priority SHALL be: trap (when compiled in) > redirect_i > fire (pc_o+4) > hold.
REQ-019 Redirect SHALL take effect next cycle whether or not fire occurs in the same cycle; the same-cycle fire still counts.
REQ-020 Redirect with redirect_pc_i[1:0]!=0 SHALL be ignored (PC follows lower priorities) and misalign_o SHALL pulse high for exactly the next cycle.
REQ-021 pc_o+4 SHALL wrap modulo 2^ADDR_W with no flag.
REQ-022 fetch_cnt_o SHALL increment by 1 on every fire, wrap modulo 2^CNT_W, and never change otherwise.
REQ-023 halt_i in RUN SHALL enter HALT next cycle; a same-cycle fire is counted and the PC update (incl. redirect) is applied first; HALT exits only via rst.
REQ-024 Redirect, trap, halt_i in IDLE or HALT SHALL be ignored.
REQ-025 pc_o SHALL remain stable while pc_valid_o=1 and pc_ready_i=0 unless redirect/trap.

Reset
REQ-026 On rst=1 at clock edge: state=IDLE, pc_o=RESET_VEC, pc_valid_o=0, halted_o=0, misalign_o=0, fetch_cnt_o=0.
REQ-027 rst SHALL override all other inputs, including mid-redirect and HALT.

Configuration
REQ-028 Macro PC_GEN_TRAP_EN defined: ports trap_i (input 1) and trap_pc_i (input ADDR_W) SHALL exist; trap_i in RUN loads trap_pc_i (bits [1:0] forced to 0) next cycle, highest priority, never misaligned.
REQ-029 PC_GEN_TRAP_EN undefined: trap ports SHALL be absent and behaviour identical to trap_i=0.

Verification
REQ-030 rst 1 cycle, ready=1 -> cycle1 valid=0 pc=80000000; cycle2 valid=1 pc=80000000; cycle3 pc=80000004, cnt=1.
REQ-031 RUN, ready=0 for 3 cycles -> pc_o constant, cnt unchanged; ready=1 -> pc+4.
REQ-032 redirect_i=1, target=80001000, ready=0 -> next pc=80001000; target=80001002 -> pc=old+4 if fire, misalign_o=1 one cycle.
REQ-033 ADDR_W=32, pc=FFFFFFFC, fire -> pc=00000000, no error.
REQ-034 halt_i with fire at pc=80000010 -> cnt+1, pc=80000014, halted_o=1, valid=0; later redirect ignored; rst -> IDLE, pc=RESET_VEC.
REQ-035 PC_GEN_TRAP_EN: trap_i and redirect_i same cycle, trap_pc_i=80000103 -> pc=80000100, misalign_o=0.

Source files
------------

// File: rtl/pc_gen.sv
// Fetch program-counter generator: IDLE -> RUN -> HALT, with redirect, halt and accepted-fetch count.
// Optional trap redirect port pair is compiled in when PC_GEN_TRAP_EN is defined.
module pc_gen #(
  parameter int          ADDR_W    = 64,
  parameter logic [63:0] RESET_VEC = 64'h0000_0000_8000_0000,
  parameter int          CNT_W     = 64
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] pc_o,
  output logic              pc_valid_o,
  input  logic              pc_ready_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  input  logic              halt_i,
`ifdef PC_GEN_TRAP_EN
  input  logic              trap_i,
  input  logic [ADDR_W-1:0] trap_pc_i,
`endif
  output logic              halted_o,
  output logic              misalign_o,
  output logic [CNT_W-1:0]  fetch_cnt_o
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HALT
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                misalign_q, misalign_d;
  logic                fire;

  assign pc_valid_o  = (state_q == RUN);
  assign halted_o    = (state_q == HALT);
  assign pc_o        = pc_q;
  assign fetch_cnt_o = cnt_q;
  assign misalign_o  = misalign_q;
  assign fire        = pc_valid_o & pc_ready_i;

  // Later assignments in RUN override earlier ones, which encodes the
  // next-PC priority: trap > redirect > sequential fire > hold.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d    = state_q;
    pc_d       = pc_q;
    cnt_d      = cnt_q;
    misalign_d = 1'b0;
    case (state_q)
      IDLE: state_d = RUN;
      RUN: begin
        if (fire) begin
          cnt_d = cnt_q + CNT_W'(1);
          pc_d  = pc_q + ADDR_W'(4);
        end
        if (redirect_i) begin
          if (redirect_pc_i[1:0] == 2'b00) pc_d = redirect_pc_i;
          else                             misalign_d = 1'b1;
        end
`ifdef PC_GEN_TRAP_EN
        if (trap_i) begin
          pc_d       = {trap_pc_i[ADDR_W-1:2], 2'b00};
          misalign_d = 1'b0;
        end
`endif
        if (halt_i) state_d = HALT;
      end
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      pc_q       <= RESET_VEC[ADDR_W-1:0];
      cnt_q      <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      cnt_q      <= cnt_d;
      misalign_q <= misalign_d;
    end
  end

endmodule
